seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//  Receive side of the 7-segment display bus. Samples a time-multiplexed, active-low segment/anode
//  bus and decodes each segment pattern back into its hex nibble. Keeps one nibble per digit.
//  Used as an on-chip display monitor and as the self-check in display-path benches.
// PARAMETERS
//  DIGITS         4   number of multiplexed digits (anode width), 1..8
//  STABLE_CYCLES  4   consecutive identical samples required before a capture, >=2
// PORTS
//  clk          in   1          system clock, all logic on rising edge
//  rst_n        in   1          asynchronous, active-low reset
//  seg          in   8          segment bus, active-low; [7]=dp, [6:0]=g,f,e,d,c,b,a
//  an           in   DIGITS     digit select, active-low; exactly one low = digit driven
//  digits       out  4*DIGITS   decoded nibbles; digit i at [4i+3:4i]
//  digit_valid  out  DIGITS     bit i=1: digits[i] holds a decoded, non-blank value
//  dp           out  DIGITS     captured decimal point per digit, 1=lit
//  cap_valid    out  1          1-cycle pulse: one digit captured this cycle
//  cap_idx      out  3          digit index of the capture; valid with cap_valid
//  frame_done   out  1          1-cycle pulse: every digit captured since the previous frame_done
//  err          out  1          1-cycle pulse: stable pattern matched no hex glyph and was not blank
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0, FSM=IDLE, counter=0, frame mask=0.
//  Input stage: {seg, an} are registered every cycle into smp. Cycle compare is smp vs new input.
//  FSM states:
//   IDLE    an not one-hot-low (all high or multiple low). cnt=0. Go to STABLE when an is one-hot-low.
//   STABLE  cnt increments while the input equals smp. On any change, cnt=0 and the FSM re-evaluates.
//           When cnt reaches STABLE_CYCLES-1 with an unchanged sample, capture and go to HELD.
//   HELD    no further capture. Leave to STABLE (cnt=0) or IDLE when the input changes.
//  Capture latency: outputs update on the same edge as the STABLE_CYCLES-th identical sample.
//  Decode table, seg[6:0] to nibble:
//   0:1000000  1:1111001  2:0100100  3:0110000  4:0011001  5:0010010  6:0000010  7:1111000
//   8:0000000  9:0010000  A:0100000  b:0000011  C:1000110  d:0100001  E:0000110  F:0001110
//  On capture of digit i, the index i is the position of the single low bit in an:
//   - match: digits[i]=nibble, digit_valid[i]=1, dp[i]=~seg[7], cap_valid=1, cap_idx=i.
//   - seg[6:0]=1111111 (blank): digit_valid[i]=0, digits[i] unchanged, dp[i]=~seg[7].
//     cap_valid=1, no err.
//   - any other pattern: err=1, cap_valid=0, digit i state unchanged.
//  Frame mask: bit i is set on every capture (match or blank) of digit i.
//   - When all DIGITS bits are set, frame_done pulses and the mask clears in the same cycle.
//   - Re-capturing a digit before the frame completes is harmless.
//  Simultaneous: a capture that completes the mask pulses both cap_valid and frame_done.
//  Glitch rule: a seg change of one cycle inside a dwell restarts the counter. It never captures.
//  Reset mid-dwell: all state is cleared. After release, a fresh STABLE_CYCLES run is required.
//  Widths: cnt is $clog2(STABLE_CYCLES) bits and saturates in HELD. cap_idx is zero-extended to 3 bits.
// TESTING (DIGITS=4, STABLE_CYCLES=4)
//  1. an=1110, seg=10100100 held 4 cycles -> 4th edge: digits[3:0]=2, digit_valid=0001, cap_valid=1, cap_idx=0.
//     The 5th+ cycles give no further cap_valid.
//  2. Scan an=1110/1101/1011/0111, 6 cycles each, with glyphs 1,A,d,F -> digits=16'hFDA1,
//     digit_valid=1111, frame_done pulses once with the 4th cap_valid.
//  3. an=1101, seg=10010010 for 2 cycles, one cycle of 10000010, then 10010010 for 3 cycles
//     -> no capture. A 4th matching cycle captures 5 into digit 1.
//  4. an=1011, seg=01101010 held 4 cycles -> err pulse. digit 2 and cap_valid unchanged/0.
//  5. an=0111, seg=11111111 after digit 3 held 8 -> digit_valid[3]=0, cap_valid=1, err=0.
//     seg=01000000 -> dp[3]=1, digits[15:12]=0.
//  6. an=0011 or 1111 held 10 cycles -> FSM stays IDLE, no pulses.
//     rst_n low mid-dwell -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/seg_scan_if.sv
// Display-bus monitor interface: sampled segment/anode lines in, decoded digit state out.
interface seg_scan_if #(
    parameter int DIGITS = 4
);
    logic [7:0]          seg;
    logic [DIGITS-1:0]   an;
    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0]   digit_valid;
    logic [DIGITS-1:0]   dp;
    logic                cap_valid;
    logic [2:0]          cap_idx;
    logic                frame_done;
    logic                err;

    modport master (
        output seg, an,
        input  digits, digit_valid, dp, cap_valid, cap_idx, frame_done, err
    );

    modport slave (
        input  seg, an,
        output digits, digit_valid, dp, cap_valid, cap_idx, frame_done, err
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Receive side of the multiplexed 7-segment bus: waits for a stable segment/anode pattern,
// decodes it back to a hex nibble per digit and reports per-capture and per-frame pulses.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | anode bus not one-hot-low (blanked or contended), no counting
//  STABLE | one digit driven, counting identical consecutive samples
//  HELD   | current pattern already captured, wait for the bus to change
module seg_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    seg_scan_if.slave bus
);
    localparam int               CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        STABLE,
        HELD
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          smp_seg;
    logic [DIGITS-1:0]   smp_an;

    logic [4*DIGITS-1:0] digits_q;
    logic [DIGITS-1:0]   valid_q;
    logic [DIGITS-1:0]   dp_q;
    logic [DIGITS-1:0]   mask_q;
    logic                cap_valid_q;
    logic [2:0]          cap_idx_q;
    logic                frame_done_q;
    logic                err_q;

    logic                same;
    logic                onehot;
    logic [DIGITS-1:0]   an_act;
    logic [DIGITS-1:0]   smp_act;
    logic                capture;
    logic [4:0]          dec;
    logic                hit;
    logic                blank;
    logic                take;
    logic                bad;
    logic [2:0]          idx;
    logic [DIGITS-1:0]   mask_set;
    logic                frame;

    // {hit, nibble}; a miss returns hit=0
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1000000: decode = 5'h10;
            7'b1111001: decode = 5'h11;
            7'b0100100: decode = 5'h12;
            7'b0110000: decode = 5'h13;
            7'b0011001: decode = 5'h14;
            7'b0010010: decode = 5'h15;
            7'b0000010: decode = 5'h16;
            7'b1111000: decode = 5'h17;
            7'b0000000: decode = 5'h18;
            7'b0010000: decode = 5'h19;
            7'b0100000: decode = 5'h1A;
            7'b0000011: decode = 5'h1B;
            7'b1000110: decode = 5'h1C;
            7'b0100001: decode = 5'h1D;
            7'b0000110: decode = 5'h1E;
            7'b0001110: decode = 5'h1F;
            default:    decode = 5'h00;
        endcase
    endfunction

    function automatic logic [2:0] low_idx(input logic [DIGITS-1:0] a);
        low_idx = 3'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!a[i]) low_idx = 3'(i);
        end
    endfunction

    always_comb begin
        an_act  = ~bus.an;
        smp_act = ~smp_an;
        onehot  = (an_act != '0) && ((an_act & (an_act - DIGITS'(1))) == '0);
        same    = (bus.seg == smp_seg) && (bus.an == smp_an);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            smp_seg <= '0;
            smp_an  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            smp_seg <= bus.seg;
            smp_an  <= bus.an;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (onehot) state_d = STABLE;
            end
            STABLE: begin
                if (!same) begin
                    cnt_d   = '0;
                    state_d = onehot ? STABLE : IDLE;
                end else if (cnt_q == CNT_CAP) begin
                    // this edge registers the STABLE_CYCLES-th identical sample
                    capture = 1'b1;
                    cnt_d   = CNT_MAX;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!same) begin
                    cnt_d   = '0;
                    state_d = onehot ? STABLE : IDLE;
                end else begin
                    cnt_d = CNT_MAX;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        dec      = decode(smp_seg[6:0]);
        hit      = dec[4];
        blank    = (smp_seg[6:0] == 7'h7F);
        idx      = low_idx(smp_an);
        take     = capture && (hit || blank);
        bad      = capture && !hit && !blank;
        mask_set = take ? (mask_q | smp_act) : mask_q;
        frame    = take && (&mask_set);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q     <= '0;
            valid_q      <= '0;
            dp_q         <= '0;
            mask_q       <= '0;
            cap_valid_q  <= 1'b0;
            cap_idx_q    <= 3'd0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            cap_valid_q  <= take;
            err_q        <= bad;
            frame_done_q <= frame;
            if (take) begin
                cap_idx_q <= idx;
                mask_q    <= frame ? '0 : mask_set;
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx == 3'(i)) begin
                        dp_q[i]    <= ~smp_seg[7];
                        valid_q[i] <= hit;
                        if (hit) digits_q[4*i +: 4] <= dec[3:0];
                    end
                end
            end
        end
    end

    assign bus.digits      = digits_q;
    assign bus.digit_valid = valid_q;
    assign bus.dp          = dp_q;
    assign bus.cap_valid   = cap_valid_q;
    assign bus.cap_idx     = cap_idx_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (DIGITS=4, STABLE_CYCLES=4).
module tb_seg_scan_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   caps, errs, frames, frame_caps, first_cap;

    always #5 clk = ~clk;

    seg_scan_if #(.DIGITS(4)) bus ();

    seg_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Drive a pattern for n cycles and tally the pulses seen after each edge.
    task automatic hold(input logic [7:0] s, input logic [3:0] a, input int n);
        bus.seg = s;
        bus.an  = a;
        caps = 0; errs = 0; frames = 0; frame_caps = 0; first_cap = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (bus.cap_valid === 1'b1) begin
                caps++;
                if (first_cap == 0) first_cap = i;
            end
            if (bus.err === 1'b1) errs++;
            if (bus.frame_done === 1'b1) begin
                frames++;
                if (bus.cap_valid === 1'b1) frame_caps++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.seg = 8'hFF;
        bus.an  = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.digits, bus.digit_valid, bus.dp} !== 24'h0) begin
            failures++;
            $display("FAIL reset_state got digits=%h valid=%b dp=%b exp all 0", bus.digits, bus.digit_valid, bus.dp);
        end
        checks++;
        if ({bus.cap_valid, bus.cap_idx, bus.frame_done, bus.err} !== 6'h0) begin
            failures++;
            $display("FAIL reset_pulses got cap=%b idx=%0d frame=%b err=%b exp 0", bus.cap_valid, bus.cap_idx, bus.frame_done, bus.err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_capture();
        hold(8'hA4, 4'b1110, 4);
        checks++;
        if (caps !== 1 || first_cap !== 4) begin
            failures++;
            $display("FAIL cap_latency got caps=%0d first=%0d exp caps=1 first=4", caps, first_cap);
        end
        checks++;
        if (bus.digits !== 16'h0002 || bus.digit_valid !== 4'b0001 || bus.cap_idx !== 3'd0) begin
            failures++;
            $display("FAIL cap_digit0 got digits=%h valid=%b idx=%0d exp 0002 0001 0", bus.digits, bus.digit_valid, bus.cap_idx);
        end
        hold(8'hA4, 4'b1110, 3);
        checks++;
        if (caps !== 0) begin
            failures++;
            $display("FAIL held_no_recap got caps=%0d exp 0", caps);
        end
    endtask

    task automatic test_scan_frame();
        logic [7:0] g [4];
        logic [3:0] a [4];
        int exp_f;
        g = '{8'hF9, 8'hA0, 8'hA1, 8'h8E};
        a = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int d = 0; d < 4; d++) begin
            hold(g[d], a[d], 6);
            exp_f = (d == 3) ? 1 : 0;
            checks++;
            if (caps !== 1 || frames !== exp_f || frame_caps !== exp_f || bus.cap_idx !== 3'(d)) begin
                failures++;
                $display("FAIL scan_digit%0d got caps=%0d frames=%0d fcap=%0d idx=%0d exp 1 %0d %0d %0d",
                         d, caps, frames, frame_caps, bus.cap_idx, exp_f, exp_f, d);
            end
        end
        checks++;
        if (bus.digits !== 16'hFDA1 || bus.digit_valid !== 4'b1111 || bus.dp !== 4'b0000) begin
            failures++;
            $display("FAIL scan_result got digits=%h valid=%b dp=%b exp FDA1 1111 0000", bus.digits, bus.digit_valid, bus.dp);
        end
    endtask

    task automatic test_glitch();
        int total;
        hold(8'h92, 4'b1101, 2);
        total = caps;
        hold(8'h82, 4'b1101, 1);
        total += caps;
        hold(8'h92, 4'b1101, 3);
        total += caps;
        checks++;
        if (total !== 0 || bus.digits[7:4] !== 4'hA) begin
            failures++;
            $display("FAIL glitch_no_cap got caps=%0d d1=%h exp 0 A", total, bus.digits[7:4]);
        end
        hold(8'h92, 4'b1101, 1);
        checks++;
        if (caps !== 1 || bus.digits[7:4] !== 4'h5 || bus.cap_idx !== 3'd1) begin
            failures++;
            $display("FAIL glitch_recover got caps=%0d d1=%h idx=%0d exp 1 5 1", caps, bus.digits[7:4], bus.cap_idx);
        end
    endtask

    task automatic test_err();
        hold(8'h6A, 4'b1011, 4);
        checks++;
        if (errs !== 1 || caps !== 0 || frames !== 0) begin
            failures++;
            $display("FAIL err_pulse got err=%0d caps=%0d frames=%0d exp 1 0 0", errs, caps, frames);
        end
        checks++;
        if (bus.digits[11:8] !== 4'hD || bus.digit_valid[2] !== 1'b1 || bus.dp[2] !== 1'b0) begin
            failures++;
            $display("FAIL err_keep got d2=%h v2=%b dp2=%b exp D 1 0", bus.digits[11:8], bus.digit_valid[2], bus.dp[2]);
        end
    endtask

    task automatic test_blank_dp();
        hold(8'hFF, 4'b0111, 8);
        checks++;
        if (caps !== 1 || errs !== 0 || bus.digit_valid !== 4'b0111 || bus.digits[15:12] !== 4'hF) begin
            failures++;
            $display("FAIL blank got caps=%0d err=%0d valid=%b d3=%h exp 1 0 0111 F", caps, errs, bus.digit_valid, bus.digits[15:12]);
        end
        hold(8'h40, 4'b0111, 4);
        checks++;
        if (caps !== 1 || bus.dp !== 4'b1000 || bus.digits[15:12] !== 4'h0 || bus.digit_valid !== 4'b1111) begin
            failures++;
            $display("FAIL dp_zero got caps=%0d dp=%b d3=%h valid=%b exp 1 1000 0 1111", caps, bus.dp, bus.digits[15:12], bus.digit_valid);
        end
    endtask

    task automatic test_idle_and_reset();
        int total;
        hold(8'hF9, 4'b0011, 10);
        total = caps + errs + frames;
        hold(8'hF9, 4'b1111, 10);
        total += caps + errs + frames;
        checks++;
        if (total !== 0) begin
            failures++;
            $display("FAIL idle_no_pulse got pulses=%0d exp 0", total);
        end
        hold(8'hA4, 4'b1110, 2);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.digits, bus.digit_valid, bus.dp, bus.cap_valid, bus.cap_idx, bus.frame_done, bus.err} !== 30'h0) begin
            failures++;
            $display("FAIL async_reset got digits=%h valid=%b dp=%b exp all 0", bus.digits, bus.digit_valid, bus.dp);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(8'hA4, 4'b1110, 3);
        checks++;
        if (caps !== 0) begin
            failures++;
            $display("FAIL reset_fresh_dwell got caps=%0d exp 0", caps);
        end
        hold(8'hA4, 4'b1110, 1);
        checks++;
        if (caps !== 1 || bus.digits !== 16'h0002 || bus.digit_valid !== 4'b0001) begin
            failures++;
            $display("FAIL reset_recap got caps=%0d digits=%h valid=%b exp 1 0002 0001", caps, bus.digits, bus.digit_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_scan_frame();
        test_glitch();
        test_err();
        test_blank_dp();
        test_idle_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
